// File: rtl/hex_key_entry_pkg.sv
// hex_key_entry_pkg: FSM states and digit geometry shared by the hex entry block, its interface and bench
package hex_key_entry_pkg;
  typedef enum logic {COLLECT, OFFER} state_t;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W = 4;
  localparam int WORD_W = NUM_DIGITS * DIGIT_W;
endpackage

// File: rtl/hex_key_entry_if.sv
// hex_key_entry_if: valid/ready word offer (value_out, value_valid from master; value_ready from slave)
interface hex_key_entry_if;
  import hex_key_entry_pkg::*;
  logic [WORD_W-1:0] value_out;
  logic value_valid;
  logic value_ready;
  modport master(output value_out, output value_valid, input value_ready);
  modport slave(input value_out, input value_valid, output value_ready);
endinterface

// File: rtl/hex_key_entry_button.sv
// button_debounce: key_n (raw active-low) -> 2-flop sync -> debounced level -> one-cycle press pulse; clk, rst (async active-low)
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q, sync_d;
  logic level_q, level_d, prev_q, prev_d, press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done;
  always_comb begin
    sync_d = {sync_q[0], key_n};
    done = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    level_d = (sync_q[1] != level_q && done) ? ~level_q : level_q;
    cnt_d = (sync_q[1] != level_q && !done) ? cnt_q + 1'b1 : '0;
    prev_d = level_q;
    press_d = prev_q & ~level_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      level_q <= 1'b1;
      prev_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      level_q <= level_d;
      prev_q <= prev_d;
      press_q <= press_d;
      cnt_q <= cnt_d;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/hex_key_entry.sv
// hex_key_entry: debounced enter/clear keys shift sw_digit into entry_value/digit_count; full word offered on vif (master)
module hex_key_entry
  import hex_key_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGIT_W-1:0]    sw_digit,
  input  logic                  key_enter_n,
  input  logic                  key_clear_n,
  output logic [WORD_W-1:0]     entry_value,
  output logic [2:0]            digit_count,
  hex_key_entry_if.master       vif
);
  state_t state_q, state_d;
  logic [WORD_W-1:0] entry_q, entry_d, vout_q, vout_d, shifted;
  logic [2:0] count_q, count_d;
  logic valid_q, valid_d, enter_p, clear_p;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .rst(rst), .key_n(key_enter_n), .press(enter_p)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .rst(rst), .key_n(key_clear_n), .press(clear_p)
  );
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    count_d = count_q;
    vout_d = vout_q;
    valid_d = valid_q;
    shifted = {entry_q[WORD_W-DIGIT_W-1:0], sw_digit};
    if (state_q == OFFER) begin
      if (vif.value_ready || clear_p) begin
        state_d = COLLECT;
        valid_d = 1'b0;
        entry_d = '0;
        count_d = '0;
      end
    end else if (clear_p) begin
      entry_d = '0;
      count_d = '0;
    end else if (enter_p) begin
      entry_d = shifted;
      count_d = count_q + 3'd1;
      if (count_q == 3'(NUM_DIGITS - 1)) begin
        state_d = OFFER;
        valid_d = 1'b1;
        vout_d = shifted;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      entry_q <= '0;
      count_q <= '0;
      vout_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      vout_q <= vout_d;
      valid_q <= valid_d;
    end
  end
  assign entry_value = entry_q;
  assign digit_count = count_q;
  assign vif.value_out = vout_q;
  assign vif.value_valid = valid_q;
endmodule

// File: tb/tb_hex_key_entry.sv
// tb_hex_key_entry: directed vectors plus random key traffic checked against a history-based reference model
module tb_hex_key_entry;
  import hex_key_entry_pkg::*;
  localparam int D = 4;
  logic clk = 0, rst = 1, ready = 0;
  logic [3:0] sw_digit = 0;
  logic key_enter_n = 1, key_clear_n = 1;
  logic [15:0] entry_value;
  logic [2:0] digit_count;
  int checks = 0, fails = 0;
  bit mon_en = 0;
  hex_key_entry_if vif();
  assign vif.value_ready = ready;
  hex_key_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .sw_digit(sw_digit), .key_enter_n(key_enter_n),
    .key_clear_n(key_clear_n), .entry_value(entry_value), .digit_count(digit_count), .vif(vif)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a button level flips when the last D synchronized samples all disagree with it;
  // a press becomes visible to the entry logic two edges after the level falls.
  bit eh[$], ch[$];
  bit e_lvl, c_lvl, e_fell, c_fell, e_pr, c_pr, m_off, ef, cf;
  int m_entry, m_cnt, m_vout;

  function automatic bit flips(input bit h[$], input bit lvl);
    for (int i = 1; i <= D; i++) if (h[h.size() - 1 - i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eh = {};
      ch = {};
      repeat (D + 2) begin
        eh.push_back(1'b1);
        ch.push_back(1'b1);
      end
      e_lvl = 1; c_lvl = 1; e_fell = 0; c_fell = 0; e_pr = 0; c_pr = 0;
      m_off = 0; m_entry = 0; m_cnt = 0; m_vout = 0;
    end else begin
      if (m_off) begin
        if (ready || c_pr) begin
          m_off = 0; m_entry = 0; m_cnt = 0;
        end
      end else if (c_pr) begin
        m_entry = 0; m_cnt = 0;
      end else if (e_pr) begin
        m_entry = (m_entry * 16 + int'(sw_digit)) % 65536;
        m_cnt++;
        if (m_cnt == NUM_DIGITS) begin
          m_off = 1; m_vout = m_entry;
        end
      end
      ef = flips(eh, e_lvl);
      cf = flips(ch, c_lvl);
      if (ef) e_lvl = !e_lvl;
      if (cf) c_lvl = !c_lvl;
      e_pr = e_fell; c_pr = c_fell;
      e_fell = ef && !e_lvl;
      c_fell = cf && !c_lvl;
      eh.push_back(key_enter_n);
      ch.push_back(key_clear_n);
    end
  end

  always @(negedge clk) begin
    if (rst && mon_en) begin
      chk("mon_entry", 32'(entry_value), m_entry);
      chk("mon_count", 32'(digit_count), m_cnt);
      chk("mon_valid", 32'(vif.value_valid), 32'(m_off));
      if (m_off) chk("mon_vout", 32'(vif.value_out), m_vout);
    end
  end

  task automatic press(input bit e, input bit c, input logic [3:0] d);
    @(negedge clk);
    sw_digit = d;
    key_enter_n = !e;
    key_clear_n = !c;
    repeat (10) @(negedge clk);
    key_enter_n = 1;
    key_clear_n = 1;
    repeat (D + 4) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  sw;
    logic [15:0] entry;
    logic [2:0]  cnt;
    logic        valid;
  } vec_t;
  vec_t vecs[4];
  int elen, clen;

  initial begin
    vecs[0] = '{4'h1, 16'h0001, 3'd1, 1'b0};
    vecs[1] = '{4'h2, 16'h0012, 3'd2, 1'b0};
    vecs[2] = '{4'hA, 16'h012A, 3'd3, 1'b0};
    vecs[3] = '{4'hF, 16'h12AF, 3'd4, 1'b1};
    #1 rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_entry", 32'(entry_value), 0);
    chk("rst_count", 32'(digit_count), 0);
    chk("rst_valid", 32'(vif.value_valid), 0);
    chk("rst_vout", 32'(vif.value_out), 0);
    rst = 1;
    mon_en = 1;
    for (int i = 0; i < 4; i++) begin
      press(1, 0, vecs[i].sw);
      chk("vec_entry", 32'(entry_value), 32'(vecs[i].entry));
      chk("vec_count", 32'(digit_count), 32'(vecs[i].cnt));
      chk("vec_valid", 32'(vif.value_valid), 32'(vecs[i].valid));
    end
    chk("offer_vout", 32'(vif.value_out), 32'h12AF);
    for (int i = 0; i < 3; i++) begin
      press(1, 0, 4'(3 + i));
      chk("stable_vout", 32'(vif.value_out), 32'h12AF);
      chk("stable_count", 32'(digit_count), 4);
      chk("stable_valid", 32'(vif.value_valid), 1);
    end
    ready = 1;
    @(negedge clk);
    ready = 0;
    chk("xfer_valid", 32'(vif.value_valid), 0);
    chk("xfer_entry", 32'(entry_value), 0);
    chk("xfer_count", 32'(digit_count), 0);
    key_enter_n = 0; repeat (3) @(negedge clk);
    key_enter_n = 1; repeat (2) @(negedge clk);
    key_enter_n = 0; repeat (3) @(negedge clk);
    key_enter_n = 1; repeat (12) @(negedge clk);
    chk("bounce_entry", 32'(entry_value), 0);
    chk("bounce_count", 32'(digit_count), 0);
    sw_digit = 4'h5;
    key_enter_n = 0;
    repeat (7) @(negedge clk);
    chk("edge7_count", 32'(digit_count), 0);
    @(negedge clk);
    chk("edge8_count", 32'(digit_count), 1);
    chk("edge8_entry", 32'(entry_value), 5);
    repeat (2) @(negedge clk);
    key_enter_n = 1;
    repeat (12) @(negedge clk);
    chk("single_count", 32'(digit_count), 1);
    press(1, 0, 4'h7);
    chk("two_entry", 32'(entry_value), 32'h0057);
    press(0, 1, 4'h0);
    chk("clr_entry", 32'(entry_value), 0);
    chk("clr_count", 32'(digit_count), 0);
    for (int i = 0; i < 4; i++) press(1, 0, 4'(9 - i));
    chk("pre_abort_valid", 32'(vif.value_valid), 1);
    press(0, 1, 4'h0);
    chk("abort_valid", 32'(vif.value_valid), 0);
    chk("abort_entry", 32'(entry_value), 0);
    chk("abort_count", 32'(digit_count), 0);
    press(1, 0, 4'h2);
    press(1, 1, 4'h4);
    chk("both_entry", 32'(entry_value), 0);
    chk("both_count", 32'(digit_count), 0);
    press(1, 0, 4'hC); press(1, 0, 4'hA); press(1, 0, 4'hF); press(1, 0, 4'hE);
    chk("pre_rst_vout", 32'(vif.value_out), 32'hCAFE);
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("arst_entry", 32'(entry_value), 0);
    chk("arst_count", 32'(digit_count), 0);
    chk("arst_valid", 32'(vif.value_valid), 0);
    chk("arst_vout", 32'(vif.value_out), 0);
    @(negedge clk);
    rst = 1;
    press(1, 0, 4'h1); press(1, 0, 4'h2); press(1, 0, 4'h3); press(1, 0, 4'h4);
    chk("fresh_valid", 32'(vif.value_valid), 1);
    chk("fresh_vout", 32'(vif.value_out), 32'h1234);
    ready = 1;
    @(negedge clk);
    ready = 0;
    elen = 0;
    clen = 0;
    repeat (1500) begin
      @(negedge clk);
      if (elen == 0) begin
        key_enter_n = 1'($urandom_range(0, 1));
        elen = $urandom_range(1, 12);
        sw_digit = 4'($urandom);
      end
      elen--;
      if (clen == 0) begin
        key_clear_n = ($urandom_range(0, 5) != 0);
        clen = $urandom_range(1, 12);
      end
      clen--;
      ready = ($urandom_range(0, 3) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/hex_key_entry.md
# hex_key_entry

User-input front end for the register/ALU datapath: the counterpart of the 7-segment hex display path. It debounces two board push-buttons and shifts four hex digits, read from four slide switches, into a 16-bit entry register. It then offers the completed word to the datapath FSM over a valid/ready handshake. The live `entry_value` is suitable for driving the existing four-digit display while typing.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive stable cycles before a button level is accepted.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `sw_digit`  in  4  hex digit to enter, sampled on an enter press
- `key_enter_n`  in  1  raw enter button, active-low, asynchronous to `clk`
- `key_clear_n`  in  1  raw clear button, active-low, asynchronous to `clk`
- `entry_value`  out  16  partially or fully entered word (display feed)
- `digit_count`  out  3  digits entered so far, 0..4
- `value_out`  out  16  offered word, valid only while `value_valid`=1
- `value_valid`  out  1  offer pending
- `value_ready`  in  1  consumer accepts the offer

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
  - Debounced level resets to 1 (released).
  - A counter restarts on any mismatch between the synchronized input and the debounced level.
  - The level flips once the mismatch persists `DEBOUNCE_CYCLES` consecutive cycles.
  - A registered one-cycle press pulse fires on a debounced 1→0 transition.
  - Releases produce no pulse.
- FSM states:
  - `COLLECT` (reset state)
  - `OFFER`
- `COLLECT` behaviour:
  - Enter pulse: `entry_value` ← {`entry_value[11:0]`, `sw_digit`}, `digit_count`+1.
  - When the count reaches 4, go to `OFFER`: `value_out` ← the new entry, `value_valid` ← 1.
- `OFFER` behaviour:
  - `value_valid` and `value_out` are held stable until the transfer completes.
  - Enter pulses are ignored.
  - When `value_valid` & `value_ready` are both high at a clock edge, the transfer completes. On that edge: `value_valid` ← 0, `entry_value` ← 0, `digit_count` ← 0, state → `COLLECT`.
- Clear pulse:
  - In `COLLECT`: `entry_value` ← 0, `digit_count` ← 0.
  - In `OFFER` without `value_ready`: abort the offer; `value_valid` ← 0, clear entry, return to `COLLECT`.
- Simultaneous events:
  - Clear and enter pulses in the same cycle: clear wins, and the digit is discarded.
  - Clear and `value_ready` in `OFFER`: the transfer counts as completed. The resulting state is the same as a plain transfer.
- `value_ready` outside `OFFER` has no effect.
- Reset (asynchronous, any time, including mid-entry or mid-offer). All of the following are cleared:
  - `entry_value` = 0, `digit_count` = 0
  - `value_out` = 0, `value_valid` = 0
  - state = `COLLECT`
  - debounced levels = 1, press pulses = 0, debounce counters = 0

## Timing
- Press latency: raw falling edge at edge 0 → synchronized at edge 2 → debounced level falls at edge 2+`DEBOUNCE_CYCLES` → press pulse high after edge 3+`DEBOUNCE_CYCLES` → `entry_value`/`digit_count` update at edge 4+`DEBOUNCE_CYCLES`.
- The 4th digit's update edge also sets `value_valid`.
- Handshake: one transfer per accepted edge. `value_valid` falls on the accepting edge. The earliest next offer follows four more presses.
- At most one press pulse per button per physical press. Glitches shorter than `DEBOUNCE_CYCLES` produce nothing.

## Structure
- Shared package:
  - FSM state encoding (`COLLECT`, `OFFER`)
  - constant `NUM_DIGITS`=4
  - constant `DIGIT_W`=4
- Sub-module `button_debounce`: synchronizer, debounce counter, and press pulse, parameterized by `DEBOUNCE_CYCLES`. It is instantiated twice, once for enter and once for clear.
- Counter width is ceil(log2(`DEBOUNCE_CYCLES`+1)).

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.

- **Entry and transfer:** press enter with `sw_digit` = 1, 2, A, F in turn, `value_ready`=0 → `entry_value` steps 0x0001, 0x0012, 0x012A, 0x12AF. `digit_count` reaches 4, `value_valid`=1, `value_out`=0x12AF. Then assert `value_ready` → `value_valid`, `entry_value` and `digit_count` all 0 next edge.
- **Bounce rejection:** enter low 3 cycles, high 2, low 3, then high → no pulse, `entry_value` unchanged. Enter held low 10 cycles → exactly one update, at edge 8 after the final fall.
- **Clear behaviour:** clear after 2 digits → 0 / 0. Clear during `OFFER` with `value_ready`=0 → `value_valid` drops and no transfer occurs. Clear and enter pulses in the same cycle → entry 0, count 0.
- **Offer stability:** in `OFFER`, 3 enter presses with changing `sw_digit` → `value_out` and `digit_count` unchanged.
- **Mid-offer reset:** `rst` low mid-offer, asynchronous to `clk` → all outputs 0 immediately. After release, the next 4 presses produce a fresh offer.
